// File: rtl/dmem_arbiter.sv
// Shares the data-memory RAM port between the CPU load/store path and a debug/loader requester.
// Fixed CPU priority with a starvation counter; define DMEM_ARB_RR_EN for round-robin instead.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_access_type,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_wren,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [2:0]        dbg_access_type,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic [2:0]        ram_access_type,
  input  logic [31:0]       ram_dout
);

  localparam int unsigned CNT_W   = 4;
  localparam logic        OWN_CPU = 1'b0;
  localparam logic        OWN_DBG = 1'b1;

  logic cpu_grant;
  logic dbg_grant;
  logic rd_pending_q, rd_pending_d;
  logic rd_owner_q, rd_owner_d;

  // Requester address bits above the RAM width are dropped silently.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{cpu_addr[31:ADDR_W], dbg_addr[31:ADDR_W]};

`ifdef DMEM_ARB_RR_EN
  logic last_winner_q, last_winner_d;

  // Contested cycles go to whoever did not win the previous contest.
  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!reset) begin
      if (cpu_req && dbg_valid) begin
        dbg_grant = (last_winner_q == OWN_CPU);
        cpu_grant = !dbg_grant;
      end else begin
        cpu_grant = cpu_req;
        dbg_grant = dbg_valid;
      end
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (cpu_req && dbg_valid && !reset) last_winner_d = dbg_grant ? OWN_DBG : OWN_CPU;
  end
`else
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             force_dbg;

  // CPU has priority unless debug has been blocked long enough.
  always_comb begin
    force_dbg = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!reset) begin
      dbg_grant = dbg_valid && (!cpu_req || force_dbg);
      cpu_grant = cpu_req && !dbg_grant;
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (dbg_valid && !dbg_grant) begin
      starve_cnt_d = (starve_cnt_q == {CNT_W{1'b1}}) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    end
  end
`endif

  // RAM port mux; idle cycles present the CPU fields with the write enable low.
  always_comb begin
    ram_addr        = cpu_addr[ADDR_W-1:0];
    ram_din         = cpu_wdata;
    ram_access_type = cpu_access_type;
    ram_wen         = cpu_grant && cpu_wren;
    if (dbg_grant) begin
      ram_addr        = dbg_addr[ADDR_W-1:0];
      ram_din         = dbg_wdata;
      ram_access_type = dbg_access_type;
      ram_wen         = dbg_wren;
    end
  end

  always_comb begin
    cpu_stall  = cpu_req && !cpu_grant;
    dbg_ready  = dbg_grant;
    cpu_rvalid = rd_pending_q && (rd_owner_q == OWN_CPU) && !reset;
    dbg_rvalid = rd_pending_q && (rd_owner_q == OWN_DBG) && !reset;
    cpu_rdata  = cpu_rvalid ? ram_dout : 32'd0;
    dbg_rdata  = dbg_rvalid ? ram_dout : 32'd0;
  end

  always_comb begin
    rd_pending_d = (cpu_grant && !cpu_wren) || (dbg_grant && !dbg_wren);
    rd_owner_d   = dbg_grant ? OWN_DBG : OWN_CPU;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWN_CPU;
`ifdef DMEM_ARB_RR_EN
      last_winner_q <= OWN_DBG;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
`ifdef DMEM_ARB_RR_EN
      last_winner_q <= last_winner_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: RAM model, behavioural reference model and directed vectors.
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned LIMIT  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clock = 1'b0;
  logic reset;
  logic cpu_req, cpu_wren, dbg_valid, dbg_wren;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [2:0] cpu_access_type, dbg_access_type;
  logic cpu_stall, cpu_rvalid, dbg_ready, dbg_rvalid, ram_wen;
  logic [31:0] cpu_rdata, dbg_rdata, ram_din, ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0] ram_access_type;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_access_type(cpu_access_type), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_wren(dbg_wren),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_access_type(dbg_access_type),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_access_type(ram_access_type), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: read data appears the cycle after the address.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clock) begin
    ram_dout <= ram_mem[ram_addr];
    if (ram_wen) ram_mem[ram_addr] <= ram_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] m_mem [DEPTH];
  int          m_blocked = 0;
  bit          m_last_dbg = 1'b1;
  bit          m_pend = 1'b0;
  bit          m_pend_dbg = 1'b0;
  logic [31:0] m_pend_data = 32'd0;

  always @(negedge clock) begin
    bit eg_cpu, eg_dbg, exp_wen, cv, dv;
    logic [31:0] a_sel, mask;
    mask = (32'd1 << ADDR_W) - 32'd1;
    eg_cpu = 1'b0;
    eg_dbg = 1'b0;
    if (!reset) begin
      if (cpu_req && dbg_valid) begin
`ifdef DMEM_ARB_RR_EN
        eg_dbg = !m_last_dbg;
`else
        eg_dbg = (m_blocked >= int'(LIMIT));
`endif
        eg_cpu = !eg_dbg;
      end else begin
        eg_cpu = cpu_req;
        eg_dbg = dbg_valid;
      end
    end
    a_sel   = (eg_dbg ? dbg_addr : cpu_addr) & mask;
    exp_wen = (eg_cpu && cpu_wren) || (eg_dbg && dbg_wren);
    cv = !reset && m_pend && !m_pend_dbg;
    dv = !reset && m_pend && m_pend_dbg;
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eg_cpu));
    chk("dbg_ready", 32'(dbg_ready), 32'(eg_dbg));
    chk("ram_wen", 32'(ram_wen), 32'(exp_wen));
    chk("ram_addr", 32'(ram_addr), a_sel);
    chk("ram_din", ram_din, eg_dbg ? dbg_wdata : cpu_wdata);
    chk("ram_access_type", 32'(ram_access_type), 32'(eg_dbg ? dbg_access_type : cpu_access_type));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(cv));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(dv));
    chk("cpu_rdata", cpu_rdata, cv ? m_pend_data : 32'd0);
    chk("dbg_rdata", dbg_rdata, dv ? m_pend_data : 32'd0);
    // Advance the model to the next cycle.
    if (reset) begin
      m_blocked = 0;
      m_pend = 1'b0;
      m_last_dbg = 1'b1;
    end else begin
      if (cpu_req && dbg_valid) m_last_dbg = eg_dbg;
      m_blocked = (dbg_valid && !eg_dbg) ? ((m_blocked < 15) ? m_blocked + 1 : 15) : 0;
      m_pend = (eg_cpu && !cpu_wren) || (eg_dbg && !dbg_wren);
      m_pend_dbg = eg_dbg;
      if (m_pend) m_pend_data = m_mem[a_sel];
      if (exp_wen) m_mem[a_sel] = eg_dbg ? dbg_wdata : cpu_wdata;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_wren = wr; cpu_addr = a; cpu_wdata = d; cpu_access_type = 3'd2;
  endtask

  task automatic dbg(input bit v, input bit wr, input logic [31:0] a, input logic [31:0] d);
    dbg_valid = v; dbg_wren = wr; dbg_addr = a; dbg_wdata = d; dbg_access_type = 3'd5;
  endtask

  logic [14:0] grant_mask, stall_mask, exp_mask;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram_mem[i] = 32'd0;
      m_mem[i] = 32'd0;
    end
    reset = 1'b1;
    cpu(1, 1, 32'h10, 32'h55);
    dbg(0, 0, 32'h0, 32'h0);
    // Reset held with a pending CPU store.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_ram_wen", 32'(ram_wen), 32'd0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'd1);
      chk("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      tick();
    end
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_store_wen", 32'(ram_wen), 32'd1);
    chk("post_rst_store_stall", 32'(cpu_stall), 32'd0);
    tick();

    // CPU store then load.
    cpu(1, 1, 32'h20, 32'hDEADBEEF);
    @(negedge clock);
    chk("cpu_store_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu(1, 0, 32'h20, 32'h0);
    @(negedge clock);
    chk("cpu_load_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu(0, 0, 32'h20, 32'h0);
    @(negedge clock);
    chk("cpu_load_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("cpu_load_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_load_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    tick();

    // Debug preload then interleaved reads.
    dbg(1, 1, 32'h40, 32'd7); tick();
    dbg(1, 1, 32'h44, 32'd9); tick();
    dbg(1, 0, 32'h40, 32'd0); tick();
    dbg(0, 0, 32'h0, 32'd0);
    cpu(1, 0, 32'h44, 32'h0);
    @(negedge clock);
    chk("il_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("il_dbg_rdata", dbg_rdata, 32'd7);
    chk("il_cpu_rvalid_a", 32'(cpu_rvalid), 32'd0);
    tick();
    cpu(0, 0, 32'h0, 32'h0);
    @(negedge clock);
    chk("il_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("il_cpu_rdata", cpu_rdata, 32'd9);
    chk("il_dbg_rvalid_b", 32'(dbg_rvalid), 32'd0);
    tick();

    // Continuous contention for 15 cycles.
    cpu(1, 0, 32'h44, 32'h0);
    dbg(1, 0, 32'h40, 32'h0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      grant_mask[i] = dbg_ready;
      stall_mask[i] = cpu_stall;
      tick();
    end
`ifdef DMEM_ARB_RR_EN
    exp_mask = 15'h2AAA;
`else
    exp_mask = 15'h4210;
`endif
    chk("contend_dbg_grants", 32'(grant_mask), 32'(exp_mask));
    chk("contend_cpu_stalls", 32'(stall_mask), 32'(exp_mask));

    // Debug drops before being granted, then contends again.
    cpu(0, 0, 32'h0, 32'h0); dbg(0, 0, 32'h0, 32'h0); tick();
    cpu(1, 1, 32'h80, 32'h1234);
    dbg(1, 1, 32'h84, 32'h5678);
    tick(); tick();
    dbg(0, 0, 32'h0, 32'h0); tick();
    dbg(1, 0, 32'h84, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    cpu(0, 0, 32'h0, 32'h0); dbg(0, 0, 32'h0, 32'h0); tick();

    // Reset arriving while a CPU load is pending.
    cpu(1, 0, 32'h20, 32'h0); tick();
    cpu(0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("midrd_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("midrd_after_rvalid", 32'(cpu_rvalid), 32'd0);
    tick();

    // Upper address bits are ignored.
    cpu(1, 1, 32'hFFFF_C020, 32'hA5A5_0001);
    @(negedge clock);
    chk("trunc_addr", 32'(ram_addr), 32'h0000_0020);
    tick();
    cpu(1, 0, 32'h0000_0020, 32'h0); tick();
    cpu(0, 0, 32'h0, 32'h0);
    @(negedge clock);
    chk("trunc_readback", cpu_rdata, 32'hA5A5_0001);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
